c4_turn_ctrl: RTL
=================

Name: c4_turn_ctrl

Overview:
- Turn sequencer for the Connect-4 board and win-check datapath.
- Accepts one column drop request per turn, computes the landing row from per-column fill counters, and rejects full or out-of-range columns.
- Issues a single-cycle board write, waits for the win checker to settle, then samples its win flag.
- Declares win or draw, or hands the turn to the other player.

Parameters:
- ROWS, 6, board rows; legal landing rows are 0 (top) to ROWS-1 (bottom).
- COLS, 7, board columns; legal columns are 0 to COLS-1.
- WIN_LAT, 1, cycles between the write strobe and a valid win-checker flag; range 1 to 7.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- new_game  in  1  synchronous clear pulse; same effect as rst, one cycle later.
- move_valid  in  1  drop request present.
- move_col  in  3  requested column.
- move_ready  out  1  controller can accept a request.
- winflag  in  1  win-checker result.
- wr_en  out  1  single-cycle board write strobe.
- wr_row  out  3  landing row.
- wr_col  out  3  landing column.
- player  out  1  side to move; 1 = player one (board code 2'd1), 0 = player two (board code 2'd2).
- illegal  out  1  single-cycle reject pulse.
- game_over  out  1  game finished.
- winner  out  2  00 none, 01 player one, 10 player two.
- draw  out  1  board full with no win.

Behaviour:
- Reset (rst high, async):
  - State = IDLE.
  - All fill counters = 0; move counter = 0.
  - player = 1.
  - move_ready = 1.
  - wr_en, illegal, game_over, draw = 0.
  - winner = 00; wr_row = 0; wr_col = 0.
- new_game: clears the same state synchronously on the next clk edge, from any state, and has priority over everything else.
- States: IDLE, CHECK, WRITE, EVAL, DONE.
- IDLE:
  - move_ready = 1.
  - On move_valid && move_ready, capture move_col and go to CHECK.
  - move_ready = 0 in every other state.
- CHECK (1 cycle):
  - If captured column >= COLS, or that column's fill == ROWS: pulse illegal for this cycle, return to IDLE, leave player and counters unchanged.
  - Otherwise load wr_row = ROWS-1-fill and wr_col = column, then go to WRITE.
- WRITE (1 cycle):
  - wr_en = 1; wr_row and wr_col stay stable.
  - Column fill increments and the move counter increments at the end of this cycle.
  - Go to EVAL with the wait counter loaded to WIN_LAT.
- EVAL:
  - Decrement the wait counter each cycle; when it reaches 0, sample winflag in that cycle.
  - winflag = 1: go to DONE, winner = player ? 01 : 10.
  - Else if move count == ROWS*COLS: go to DONE, draw = 1.
  - Else: toggle player and go to IDLE.
  - A winflag high before the sample cycle is ignored.
- DONE:
  - game_over = 1; winner and draw held.
  - move_valid is ignored and illegal is never pulsed.
  - Exit only via rst or new_game.
- Latency: request accepted in cycle N gives CHECK in N+1, wr_en in N+2, sample at N+2+WIN_LAT, move_ready back high in cycle N+3+WIN_LAT.
- Widths:
  - Fill counters are 3 bits and saturate at ROWS; they never wrap.
  - Move counter is 6 bits.
  - move_col = 7 is always illegal.
- Simultaneous events:
  - rst dominates all.
  - new_game dominates move_valid.
  - A win on the final cell reports win, not draw.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset then drop col 3 -> wr_en exactly 2 cycles after acceptance with wr_row=5, wr_col=3; with WIN_LAT=1 and winflag=0, player goes 1->0 and move_ready returns 4 cycles after acceptance.
- Seven drops into col 0 -> rows 5,4,3,2,1,0 written, alternating players; seventh drop gives one illegal pulse, no wr_en, player unchanged.
- move_col=7 -> illegal pulse in the CHECK cycle; fill counters and player unchanged.
- Bench win model asserts winflag after the fourth player-one drop in col 2 -> game_over=1, winner=01; further move_valid gives no wr_en and no illegal.
- Fill all 42 cells with winflag held 0 -> after the 42nd write, draw=1, game_over=1, winner=00.
- rst asserted mid-EVAL -> all outputs go to reset values immediately with no wr_en; new_game pulse from DONE -> player=1 and the next drop in col 4 lands at row 5.

Source files
------------

// File: rtl/c4_turn_ctrl.sv
// rtl/c4_turn_ctrl.sv - Connect-4 turn sequencer: drop legality, board write, win/draw evaluation.
module c4_turn_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       move_ready,
    input  logic       winflag,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic       player,
    output logic       illegal,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    localparam logic [2:0] ROWS_L  = 3'(ROWS);
    localparam logic [3:0] COLS_L  = 4'(COLS);
    localparam logic [5:0] CELLS_L = 6'(ROWS * COLS);
    localparam logic [2:0] WAIT_L  = 3'(WIN_LAT);

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, EVAL, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] fill_q [8];
    logic [2:0] fill_d [8];
    logic [5:0] moves_q, moves_d;
    logic [2:0] col_q, col_d;
    logic [2:0] wait_q, wait_d;
    logic       move_ready_q, move_ready_d;
    logic       wr_en_q, wr_en_d;
    logic [2:0] wr_row_q, wr_row_d;
    logic [2:0] wr_col_q, wr_col_d;
    logic       player_q, player_d;
    logic       illegal_q, illegal_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic       draw_q, draw_d;
    logic       legal_w;

    assign move_ready = move_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign player     = player_q;
    assign illegal    = illegal_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;
    assign draw       = draw_q;

    // Legality is judged at acceptance so the reject pulse can be a registered output in CHECK.
    assign legal_w = ({1'b0, move_col} < COLS_L) && (fill_q[move_col] != ROWS_L);

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        moves_d      = moves_q;
        col_d        = col_q;
        wait_d       = wait_q;
        move_ready_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        player_d     = player_q;
        illegal_d    = 1'b0;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        draw_d       = draw_q;

        case (state_q)
            IDLE: begin
                if (move_valid && move_ready_q) begin
                    col_d     = move_col;
                    illegal_d = !legal_w;
                    state_d   = CHECK;
                end else begin
                    move_ready_d = 1'b1;
                end
            end
            CHECK: begin
                if (illegal_q) begin
                    state_d      = IDLE;
                    move_ready_d = 1'b1;
                end else begin
                    wr_row_d = ROWS_L - 3'd1 - fill_q[col_q];
                    wr_col_d = col_q;
                    wr_en_d  = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (fill_q[col_q] != ROWS_L) begin
                    fill_d[col_q] = fill_q[col_q] + 3'd1;
                end
                moves_d = moves_q + 6'd1;
                wait_d  = WAIT_L;
                state_d = EVAL;
            end
            EVAL: begin
                if (wait_q <= 3'd1) begin
                    if (winflag) begin
                        winner_d    = player_q ? 2'b01 : 2'b10;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (moves_q == CELLS_L) begin
                        draw_d      = 1'b1;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        player_d     = !player_q;
                        move_ready_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            DONE: ;
            default: begin
                state_d      = IDLE;
                move_ready_d = 1'b1;
            end
        endcase

        if (new_game) begin
            state_d = IDLE;
            for (int i = 0; i < 8; i++) begin
                fill_d[i] = 3'd0;
            end
            moves_d      = 6'd0;
            col_d        = 3'd0;
            wait_d       = 3'd0;
            move_ready_d = 1'b1;
            wr_en_d      = 1'b0;
            wr_row_d     = 3'd0;
            wr_col_d     = 3'd0;
            player_d     = 1'b1;
            illegal_d    = 1'b0;
            game_over_d  = 1'b0;
            winner_d     = 2'b00;
            draw_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 8; i++) begin
                fill_q[i] <= 3'd0;
            end
            moves_q      <= 6'd0;
            col_q        <= 3'd0;
            wait_q       <= 3'd0;
            move_ready_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_row_q     <= 3'd0;
            wr_col_q     <= 3'd0;
            player_q     <= 1'b1;
            illegal_q    <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            moves_q      <= moves_d;
            col_q        <= col_d;
            wait_q       <= wait_d;
            move_ready_q <= move_ready_d;
            wr_en_q      <= wr_en_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            player_q     <= player_d;
            illegal_q    <= illegal_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
        end
    end

endmodule
